// File: rtl/mfp_uart_transmitter_pkg.sv
// Shared UART definitions: FSM state encodings, frame constants and the
// clocks-per-bit divider calculation (also usable by the receive side).
package mfp_uart_transmitter_pkg;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_t;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;
    localparam int unsigned FRAME_BITS = 1 + DATA_BITS + STOP_BITS;

    // Clocks per bit, integer-truncated.
    function automatic int unsigned uart_div(input int unsigned clock_hz,
                                             input int unsigned baud);
        return clock_hz / baud;
    endfunction

endpackage

// File: rtl/mfp_uart_tx_fifo.sv
// Synchronous byte FIFO for the UART transmitter.
// Ports: clock/reset_n (async active-low), push/wdata write side,
// pop/rdata read side (rdata is the current head, valid when !empty),
// count (occupancy), full, empty.
module mfp_uart_tx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage array; no reset needed, occupancy is tracked by count.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap modulo DEPTH (power of two); count separates full from empty.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mfp_uart_transmitter.sv
// UART transmitter, 8N1, LSB first, idle-high line.
// Ports: clock/reset_n (async active-low); byte_data/byte_valid/byte_ready
// push handshake into the byte FIFO; tx registered serial line; busy while
// a frame is on the line or bytes are queued; fifo_count queued bytes
// (excluding the one being shifted); overflow sticky dropped-byte flag.
module mfp_uart_transmitter
    import mfp_uart_transmitter_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 50000000,
    parameter int unsigned BAUD_RATE       = 115200,
    parameter int unsigned FIFO_DEPTH      = 16
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [7:0]                    byte_data,
    input  logic                          byte_valid,
    output logic                          byte_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int unsigned DIV    = uart_div(CLOCK_FREQUENCY, BAUD_RATE);
    localparam int unsigned BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IDX_W  = $clog2(DATA_BITS);

    // Elaboration-time parameter sanity.
    if (DIV < 2) begin : g_div_check
        $error("mfp_uart_transmitter: CLOCK_FREQUENCY/BAUD_RATE must be >= 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
        $error("mfp_uart_transmitter: FIFO_DEPTH must be a power of two >= 2");
    end

    uart_state_t            state, state_nxt;
    logic [BAUD_W-1:0]      baud_cnt, baud_cnt_nxt;
    logic [IDX_W-1:0]       bit_idx, bit_idx_nxt;
    logic [DATA_BITS-1:0]   shift, shift_nxt;
    logic                   tx_nxt;
    logic                   pop;
    logic                   push;
    logic [7:0]             fifo_head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   bit_end;

    // Ready depends only on registered occupancy, never on a same-cycle pop.
    assign byte_ready = !fifo_full;
    assign push       = byte_valid && byte_ready;
    assign busy       = (state != UART_IDLE) || (fifo_count != '0);
    assign bit_end    = (baud_cnt == BAUD_W'(DIV - 1));

    mfp_uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .wdata   (byte_data),
        .pop     (pop),
        .rdata   (fifo_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // State, baud counter, shift register and line register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= UART_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_cnt_nxt;
            bit_idx  <= bit_idx_nxt;
            shift    <= shift_nxt;
            tx       <= tx_nxt;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_nxt    = state;
        baud_cnt_nxt = baud_cnt;
        bit_idx_nxt  = bit_idx;
        shift_nxt    = shift;
        tx_nxt       = tx;
        pop          = 1'b0;

        unique case (state)
            UART_IDLE: begin
                tx_nxt       = 1'b1;
                baud_cnt_nxt = '0;
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    shift_nxt   = fifo_head;
                    bit_idx_nxt = '0;
                    state_nxt   = UART_START;
                    tx_nxt      = 1'b0;
                end
            end
            UART_START: begin
                if (bit_end) begin
                    baud_cnt_nxt = '0;
                    state_nxt    = UART_DATA;
                    tx_nxt       = shift[0];
                end else begin
                    baud_cnt_nxt = baud_cnt + BAUD_W'(1);
                end
            end
            UART_DATA: begin
                if (bit_end) begin
                    baud_cnt_nxt = '0;
                    if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                        state_nxt = UART_STOP;
                        tx_nxt    = 1'b1;
                    end else begin
                        shift_nxt   = shift >> 1;
                        bit_idx_nxt = bit_idx + IDX_W'(1);
                        tx_nxt      = shift[1];
                    end
                end else begin
                    baud_cnt_nxt = baud_cnt + BAUD_W'(1);
                end
            end
            UART_STOP: begin
                if (bit_end) begin
                    baud_cnt_nxt = '0;
                    // Back-to-back frames: next start bit follows the stop bit directly.
                    if (!fifo_empty) begin
                        pop         = 1'b1;
                        shift_nxt   = fifo_head;
                        bit_idx_nxt = '0;
                        state_nxt   = UART_START;
                        tx_nxt      = 1'b0;
                    end else begin
                        state_nxt = UART_IDLE;
                        tx_nxt    = 1'b1;
                    end
                end else begin
                    baud_cnt_nxt = baud_cnt + BAUD_W'(1);
                end
            end
            default: begin
                state_nxt = UART_IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

    // Sticky flag for bytes offered while the FIFO was full.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (byte_valid && !byte_ready) begin
            overflow <= 1'b1;
        end
    end

endmodule
